// File: rtl/dpi_stream_ctx_engine_pkg.sv
// Shared defaults and helpers for the per-stream DFA context engine and its
// sibling regex wrappers. No ports; imported by the interface and the top.
package dpi_stream_ctx_engine_pkg;

    localparam int DEF_ST_W    = 11;  // DFA state width
    localparam int DEF_SID_W   = 6;   // stream ID width
    localparam int DEF_CNT_W   = 16;  // match counter width
    localparam int DEF_DFA_LAT = 1;   // DFA char-to-result latency

    function automatic int num_streams(input int sid_w);
        return 1 << sid_w;
    endfunction

    // Cycles from eop to the commit cycle: one input register stage, the DFA
    // latency, and one output register stage.
    function automatic int commit_depth(input int dfa_lat);
        return dfa_lat + 2;
    endfunction

endpackage

// File: rtl/dpi_stream_ctx_engine_if.sv
// Bus between the context engine and an external regex DFA core.
//  master (engine side): drives dfa_char/dfa_char_vld/dfa_state_in/dfa_state_vld,
//                        receives dfa_state_out/dfa_accept
//  slave  (DFA side)   : the mirror image
interface dpi_stream_ctx_engine_if
    import dpi_stream_ctx_engine_pkg::*;
#(
    parameter int ST_W = DEF_ST_W
);
    logic [7:0]      dfa_char;
    logic            dfa_char_vld;
    logic [ST_W-1:0] dfa_state_in;
    logic            dfa_state_vld;
    logic [ST_W-1:0] dfa_state_out;
    logic            dfa_accept;

    modport master (
        output dfa_char, dfa_char_vld, dfa_state_in, dfa_state_vld,
        input  dfa_state_out, dfa_accept
    );

    modport slave (
        input  dfa_char, dfa_char_vld, dfa_state_in, dfa_state_vld,
        output dfa_state_out, dfa_accept
    );
endinterface

// File: rtl/dpi_stream_ctx_engine_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Read-first: a read and a write to the same address in one cycle return the
// old contents. Contents are never reset.
//  clk           clock
//  we/waddr/wdata write port
//  re/raddr      read request; rdata valid the cycle after re
module dpi_stream_ctx_engine_sdp_ram #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dpi_stream_ctx_engine.sv
// Per-stream context wrapper around an external regex DFA core.
// Saves/restores DFA state per stream, registers all DFA I/O, delays eop to
// line up with the DFA result so the last byte's match is counted, and keeps
// saturating per-stream and global match counts.
//  clk, rst_n                 clock, synchronous active-low reset
//  load_state/stream_id/new_stream_id   packet start and context select
//  char_in/char_in_vld        payload bytes
//  eop/enable                 packet end; enable=1 commits state and count
//  busy/fired/count           commit in flight, sticky match, global count
//  rd_en/rd_sid/rd_count      per-stream count readout (1-cycle latency)
//  dfa                        bus to the DFA core (master side)
module dpi_stream_ctx_engine
    import dpi_stream_ctx_engine_pkg::*;
#(
    parameter int ST_W    = DEF_ST_W,
    parameter int SID_W   = DEF_SID_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DFA_LAT = DEF_DFA_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_state,
    input  logic [SID_W-1:0] stream_id,
    input  logic             new_stream_id,
    input  logic [7:0]       char_in,
    input  logic             char_in_vld,
    input  logic             eop,
    input  logic             enable,
    output logic             busy,
    output logic             fired,
    output logic [CNT_W-1:0] count,
    input  logic             rd_en,
    input  logic [SID_W-1:0] rd_sid,
    output logic [CNT_W-1:0] rd_count,
    dpi_stream_ctx_engine_if.master dfa
);
    localparam int D = commit_depth(DFA_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x, input logic inc);
        return (x == CNT_MAX) ? x : x + {{(CNT_W-1){1'b0}}, inc};
    endfunction

    logic                        load_q, load_d, new_q, new_d;
    logic [7:0]                  char_q, char_d;
    logic                        char_vld_q, char_vld_d;
    logic [ST_W-1:0]             state_in_q, state_in_d;
    logic                        state_vld_q, state_vld_d;
    logic                        accept_r_q, accept_r_d;
    logic [ST_W-1:0]             state_r_q, state_r_d;
    logic                        fired_q, fired_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [D-1:0]                pipe_vld_q, pipe_vld_d, pipe_en_q, pipe_en_d;
    logic [D-1:0][SID_W-1:0]     pipe_sid_q, pipe_sid_d;
    logic                        rd_pend_q, rd_pend_d, rd_issued_q, rd_issued_d;
    logic [SID_W-1:0]            rd_pend_sid_q, rd_pend_sid_d;
    logic [CNT_W-1:0]            rd_hold_q, rd_hold_d;

    logic                        commit, commit_wr, hit, rmw_rd, rd_req, cnt_re;
    logic [SID_W-1:0]            commit_sid, rd_req_sid, cnt_raddr;
    logic [ST_W-1:0]             ctx_rdata;
    logic [CNT_W-1:0]            cnt_rdata, cnt_wdata;

    always_comb begin
        load_d      = load_state;
        new_d       = new_stream_id;
        char_d      = char_in;
        char_vld_d  = char_in_vld;
        accept_r_d  = dfa.dfa_accept;
        state_r_d   = dfa.dfa_state_out;
        // Context RAM data arrives the cycle after load_state; present it (or
        // the fresh-stream state 0) one cycle later alongside the first byte.
        state_vld_d = load_q;
        state_in_d  = load_q ? (new_q ? '0 : ctx_rdata) : state_in_q;

        // The last stage of the eop pipe lines up with accept_r/state_r of
        // the packet's final byte.
        commit     = pipe_vld_q[D-1];
        commit_wr  = commit & pipe_en_q[D-1];
        commit_sid = pipe_sid_q[D-1];
        hit        = fired_q | accept_r_q;

        fired_d = fired_q;
        if (load_state || commit) begin
            fired_d = 1'b0;
        end else if (accept_r_q) begin
            fired_d = 1'b1;
        end

        count_d    = commit_wr ? sat_inc(count_q, hit) : count_q;
        pipe_vld_d = {pipe_vld_q[D-2:0], eop};
        pipe_en_d  = {pipe_en_q[D-2:0], enable};
        pipe_sid_d = {pipe_sid_q[D-2:0], stream_id};

        // Count RAM read port: the commit read-modify-write owns it the cycle
        // before the write; a readout request landing there retries next
        // cycle. A fresh rd_en takes precedence over a pending retry.
        rmw_rd        = pipe_vld_q[D-2];
        rd_req        = rd_en | rd_pend_q;
        rd_req_sid    = rd_en ? rd_sid : rd_pend_sid_q;
        cnt_re        = rmw_rd | rd_req;
        cnt_raddr     = rmw_rd ? pipe_sid_q[D-2] : rd_req_sid;
        rd_pend_d     = rmw_rd & rd_req;
        rd_pend_sid_d = rd_req_sid;
        rd_issued_d   = ~rmw_rd & rd_req;
        rd_hold_d     = rd_count;
        cnt_wdata     = sat_inc(cnt_rdata, hit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_q        <= 1'b0;
            new_q         <= 1'b0;
            char_q        <= '0;
            char_vld_q    <= 1'b0;
            state_in_q    <= '0;
            state_vld_q   <= 1'b0;
            accept_r_q    <= 1'b0;
            state_r_q     <= '0;
            fired_q       <= 1'b0;
            count_q       <= '0;
            pipe_vld_q    <= '0;
            pipe_en_q     <= '0;
            pipe_sid_q    <= '0;
            rd_pend_q     <= 1'b0;
            rd_pend_sid_q <= '0;
            rd_issued_q   <= 1'b0;
            rd_hold_q     <= '0;
        end else begin
            load_q        <= load_d;
            new_q         <= new_d;
            char_q        <= char_d;
            char_vld_q    <= char_vld_d;
            state_in_q    <= state_in_d;
            state_vld_q   <= state_vld_d;
            accept_r_q    <= accept_r_d;
            state_r_q     <= state_r_d;
            fired_q       <= fired_d;
            count_q       <= count_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_en_q     <= pipe_en_d;
            pipe_sid_q    <= pipe_sid_d;
            rd_pend_q     <= rd_pend_d;
            rd_pend_sid_q <= rd_pend_sid_d;
            rd_issued_q   <= rd_issued_d;
            rd_hold_q     <= rd_hold_d;
        end
    end

    dpi_stream_ctx_engine_sdp_ram #(.DW(ST_W), .AW(SID_W)) u_ctx_ram (
        .clk(clk), .we(commit_wr), .waddr(commit_sid), .wdata(state_r_q),
        .re(load_state), .raddr(stream_id), .rdata(ctx_rdata)
    );

    dpi_stream_ctx_engine_sdp_ram #(.DW(CNT_W), .AW(SID_W)) u_cnt_ram (
        .clk(clk), .we(commit_wr), .waddr(commit_sid), .wdata(cnt_wdata),
        .re(cnt_re), .raddr(cnt_raddr), .rdata(cnt_rdata)
    );

    // rd_count follows the RAM output only in the cycle after a readout;
    // otherwise it holds, so RMW reads never disturb it.
    assign rd_count          = rd_issued_q ? cnt_rdata : rd_hold_q;
    assign busy              = |pipe_vld_q;
    assign fired             = fired_q;
    assign count             = count_q;
    assign dfa.dfa_char      = char_q;
    assign dfa.dfa_char_vld  = char_vld_q;
    assign dfa.dfa_state_in  = state_in_q;
    assign dfa.dfa_state_vld = state_vld_q;
endmodule

// File: tb/tb_dpi_stream_ctx_engine.sv
`timescale 1ns/1ps
// Directed bench: three engine lanes with DFA_LAT = 0, 1, 3 share one stimulus
// stream, each with its own behavioural DFA (state += byte, accept on '!').
// A 4-bit counter width lets saturation be reached by real traffic.
module tb_dpi_stream_ctx_engine;
    localparam int ST_W  = 11;
    localparam int SID_W = 6;
    localparam int CNT_W = 4;
    localparam int NL    = 3;
    localparam int LAT_TAB [NL] = '{0, 1, 3};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_state = 1'b0, new_stream_id = 1'b0;
    logic [SID_W-1:0] stream_id = '0, rd_sid = '0;
    logic [7:0]       char_in = '0;
    logic             char_in_vld = 1'b0, eop = 1'b0, enable = 1'b0;
    logic             rd_en_l [NL];
    logic             busy_l [NL], fired_l [NL], state_vld_l [NL];
    logic [CNT_W-1:0] count_l [NL], rd_count_l [NL];
    logic [ST_W-1:0]  state_in_l [NL];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_lane
            localparam int L = LAT_TAB[gi];
            dpi_stream_ctx_engine_if #(.ST_W(ST_W)) dfa_if ();

            dpi_stream_ctx_engine #(.ST_W(ST_W), .SID_W(SID_W), .CNT_W(CNT_W), .DFA_LAT(L)) u_dut (
                .clk(clk), .rst_n(rst_n), .load_state(load_state), .stream_id(stream_id),
                .new_stream_id(new_stream_id), .char_in(char_in), .char_in_vld(char_in_vld),
                .eop(eop), .enable(enable), .busy(busy_l[gi]), .fired(fired_l[gi]),
                .count(count_l[gi]), .rd_en(rd_en_l[gi]), .rd_sid(rd_sid),
                .rd_count(rd_count_l[gi]), .dfa(dfa_if)
            );

            logic [ST_W-1:0] base, cur, st_q;
            logic            cur_acc;
            logic [ST_W-1:0] sp [4];
            logic            ap [4];

            always_comb begin
                base    = dfa_if.dfa_state_vld ? dfa_if.dfa_state_in : st_q;
                cur     = dfa_if.dfa_char_vld ? base + ST_W'(dfa_if.dfa_char) : base;
                cur_acc = dfa_if.dfa_char_vld && (dfa_if.dfa_char == 8'h21);
            end

            always @(posedge clk) begin
                if (!rst_n) begin
                    st_q <= '0;
                    for (int i = 0; i < 4; i++) begin
                        sp[i] <= '0;
                        ap[i] <= 1'b0;
                    end
                end else begin
                    st_q  <= cur;
                    sp[0] <= cur;
                    ap[0] <= cur_acc;
                    for (int i = 1; i < 4; i++) begin
                        sp[i] <= sp[i-1];
                        ap[i] <= ap[i-1];
                    end
                end
            end

            if (L == 0) begin : g_comb
                assign dfa_if.dfa_state_out = cur;
                assign dfa_if.dfa_accept    = cur_acc;
            end else begin : g_reg
                assign dfa_if.dfa_state_out = sp[L-1];
                assign dfa_if.dfa_accept    = ap[L-1];
            end

            assign state_in_l[gi]  = dfa_if.dfa_state_in;
            assign state_vld_l[gi] = dfa_if.dfa_state_vld;
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_count(input string nm, input logic [CNT_W-1:0] exp);
        for (int l = 0; l < NL; l++)
            chk($sformatf("%s_count_l%0d", nm, l), 32'(count_l[l]), 32'(exp));
    endtask

    task automatic read_cnt(input string nm, input logic [SID_W-1:0] sid, input logic [CNT_W-1:0] exp);
        rd_sid = sid;
        for (int l = 0; l < NL; l++) rd_en_l[l] = 1'b1;
        tick();
        for (int l = 0; l < NL; l++) begin
            rd_en_l[l] = 1'b0;
            chk($sformatf("%s_rd_l%0d", nm, l), 32'(rd_count_l[l]), 32'(exp));
        end
        tick();
        for (int l = 0; l < NL; l++)
            chk($sformatf("%s_rdhold_l%0d", nm, l), 32'(rd_count_l[l]), 32'(exp));
        $display("read %s sid=%0d exp=%0d", nm, sid, exp);
    endtask

    // One packet of 1-2 bytes, eop on the last byte. Checks restore at T+2,
    // busy, fired at the commit cycle, and post-commit state per lane; with
    // rd_cmt a read of sid is issued in each lane's commit write cycle.
    task automatic run_pkt(input string nm, input logic [SID_W-1:0] sid, input bit nw,
                           input logic [7:0] c0, input logic [7:0] c1, input int n,
                           input bit en, input logic [ST_W-1:0] exp_st, input bit exp_fire,
                           input bit rd_cmt, input logic [CNT_W-1:0] rd_old);
        int d;
        for (int l = 0; l < NL; l++)
            chk($sformatf("%s_ldbusy_l%0d", nm, l), 32'(busy_l[l]), 32'd0);
        load_state = 1'b1; stream_id = sid; new_stream_id = nw;
        tick();
        load_state = 1'b0; new_stream_id = 1'b0;
        for (int i = 0; i < n; i++) begin
            char_in = (i == 0) ? c0 : c1; char_in_vld = 1'b1; eop = (i == n-1); enable = en;
            tick();
            if (i == 0) begin
                for (int l = 0; l < NL; l++) begin
                    chk($sformatf("%s_stvld_l%0d", nm, l), 32'(state_vld_l[l]), 32'd1);
                    chk($sformatf("%s_stin_l%0d", nm, l), 32'(state_in_l[l]), 32'(exp_st));
                end
            end
        end
        char_in_vld = 1'b0; eop = 1'b0; char_in = '0; rd_sid = sid;
        for (int c = 1; c <= 7; c++) begin
            for (int l = 0; l < NL; l++) begin
                d = LAT_TAB[l] + 2;
                if (c == 1) chk($sformatf("%s_busy_l%0d", nm, l), 32'(busy_l[l]), 32'd1);
                if (c == d) chk($sformatf("%s_firedE_l%0d", nm, l), 32'(fired_l[l]), 32'(exp_fire));
                if (c == d + 1) begin
                    chk($sformatf("%s_idle_l%0d", nm, l), 32'(busy_l[l]), 32'd0);
                    chk($sformatf("%s_fclr_l%0d", nm, l), 32'(fired_l[l]), 32'd0);
                    if (rd_cmt) chk($sformatf("%s_rdcol_l%0d", nm, l), 32'(rd_count_l[l]), 32'(rd_old));
                end
                rd_en_l[l] = rd_cmt && (c == d);
            end
            tick();
        end
        for (int l = 0; l < NL; l++) rd_en_l[l] = 1'b0;
        $display("pkt %s sid=%0d new=%0d bytes=%0d en=%0d", nm, sid, nw, n, en);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int l = 0; l < NL; l++) rd_en_l[l] = 1'b0;
        // RAM contents start at zero in this simulator; streams are fresh.
        repeat (3) tick();
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("rst_busy_l%0d", l), 32'(busy_l[l]), 32'd0);
            chk($sformatf("rst_fired_l%0d", l), 32'(fired_l[l]), 32'd0);
            chk($sformatf("rst_count_l%0d", l), 32'(count_l[l]), 32'd0);
            chk($sformatf("rst_rd_l%0d", l), 32'(rd_count_l[l]), 32'd0);
            chk($sformatf("rst_stvld_l%0d", l), 32'(state_vld_l[l]), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // New stream, match on the last byte coincident with eop.
        run_pkt("t1", 6'd5, 1'b1, 8'h41, 8'h21, 2, 1'b1, 11'h000, 1'b0, 1'b0, 4'd0);
        chk_count("t1", 4'd1);
        read_cnt("t1", 6'd5, 4'd1);

        // Resume: A ends in 0xFF+0xA3 = 0x1A2 without a match; B restores it.
        run_pkt("t2a", 6'd3, 1'b1, 8'hFF, 8'hA3, 2, 1'b1, 11'h000, 1'b0, 1'b0, 4'd0);
        chk_count("t2a", 4'd1);
        read_cnt("t2a", 6'd3, 4'd0);
        run_pkt("t2b", 6'd3, 1'b0, 8'h21, 8'h00, 1, 1'b1, 11'h1A2, 1'b0, 1'b0, 4'd0);
        chk_count("t2b", 4'd2);
        read_cnt("t2b", 6'd3, 4'd1);

        // Disabled commit with a mid-packet match: nothing changes.
        run_pkt("t3", 6'd3, 1'b0, 8'h21, 8'h10, 2, 1'b0, 11'h1C3, 1'b1, 1'b0, 4'd0);
        chk_count("t3", 4'd2);
        read_cnt("t3", 6'd3, 4'd1);
        run_pkt("t3b", 6'd3, 1'b0, 8'h01, 8'h00, 1, 1'b1, 11'h1C3, 1'b0, 1'b0, 4'd0);
        chk_count("t3b", 4'd2);

        // Read in the commit write cycle returns the pre-commit value.
        run_pkt("t5a", 6'd9, 1'b1, 8'h21, 8'h00, 1, 1'b1, 11'h000, 1'b0, 1'b0, 4'd0);
        chk_count("t5a", 4'd3);
        run_pkt("t5b", 6'd9, 1'b0, 8'h21, 8'h00, 1, 1'b1, 11'h021, 1'b0, 1'b1, 4'd1);
        chk_count("t5b", 4'd4);
        read_cnt("t5", 6'd9, 4'd2);

        // Reset two cycles after load_state drops the packet.
        load_state = 1'b1; stream_id = 6'd10; new_stream_id = 1'b1;
        tick();
        load_state = 1'b0; new_stream_id = 1'b0;
        char_in = 8'h21; char_in_vld = 1'b1; eop = 1'b1; enable = 1'b1;
        tick();
        char_in_vld = 1'b0; eop = 1'b0; rst_n = 1'b0;
        tick();
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("t6_busy_l%0d", l), 32'(busy_l[l]), 32'd0);
            chk($sformatf("t6_fired_l%0d", l), 32'(fired_l[l]), 32'd0);
            chk($sformatf("t6_rd_l%0d", l), 32'(rd_count_l[l]), 32'd0);
        end
        chk_count("t6rst", 4'd0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk_count("t6post", 4'd0);
        $display("reset mid-packet sid=10");
        run_pkt("t6n", 6'd10, 1'b1, 8'h21, 8'h00, 1, 1'b1, 11'h000, 1'b0, 1'b0, 4'd0);
        chk_count("t6n", 4'd1);
        read_cnt("t6n", 6'd10, 4'd1);

        // Saturation: 17 matches on sid 7 push both counters past 15.
        for (int k = 0; k < 17; k++)
            run_pkt($sformatf("t4_%0d", k), 6'd7, (k == 0), 8'h21, 8'h00, 1, 1'b1,
                    ST_W'(k * 33), 1'b0, 1'b0, 4'd0);
        chk_count("t4", 4'd15);
        read_cnt("t4", 6'd7, 4'd15);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
